// File: rtl/muldiv_pkg.sv
// Shared types, opcode constants and helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int unsigned NEG_W = 64;

  // Conditional two's-complement negate; narrower values are zero-extended by the caller.
  function automatic logic [NEG_W-1:0] cond_neg(input logic [NEG_W-1:0] x, input logic en);
    return en ? (~x + NEG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide engine for the EX stage.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            op_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  input  logic            hold,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned RW = XLEN + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     acc_q, acc_d;     // mul: {partial high, multiplier}; div: low half holds dividend/quotient
  logic [RW-1:0]     rem_q, rem_d;     // divider partial remainder
  logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic              neg_q, neg_d;     // final result needs negation
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              rv_q, rv_d;

  // Operand decode for the accepting cycle: magnitudes, sign and the fast-path corner cases
  logic            src1_signed, src2_signed, neg1, neg2;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] abs1, abs2, fast_res;

  always_comb begin
    src1_signed = !(funct3 inside {F3_MULHU, F3_DIVU, F3_REMU});
    src2_signed = funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    neg1        = src1_signed & src1[XLEN-1];
    neg2        = src2_signed & src2[XLEN-1];
    abs1        = XLEN'(cond_neg(DW'(src1), neg1));
    abs2        = XLEN'(cond_neg(DW'(src2), neg2));
    div_zero    = funct3[2] && (src2 == '0);
    div_ovf     = (funct3 inside {F3_DIV, F3_REM}) &&
                  (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    fast        = div_zero || div_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU within the divide group
    if (div_zero) fast_res = funct3[1] ? src1 : '1;
    else          fast_res = funct3[1] ? '0 : src1;
  end

  // One radix-2 iteration for both datapaths plus the sign-corrected final value
  logic [RW-1:0]   mul_sum;
  logic [DW-1:0]   mul_next, mul_fix;
  logic [RW:0]     div_shift, div_diff;
  logic            div_ge;
  logic [RW-1:0]   div_rem_next;
  logic [XLEN-1:0] div_quo_next, quo_fix, rem_fix, calc_res;

  always_comb begin
    mul_sum      = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next     = {mul_sum, acc_q[XLEN-1:1]};
    div_shift    = {rem_q, acc_q[XLEN-1]};
    div_diff     = div_shift - {2'b00, opnd_q};
    div_ge       = div_shift >= {2'b00, opnd_q};
    div_rem_next = div_ge ? RW'(div_diff) : RW'(div_shift);
    div_quo_next = {acc_q[XLEN-2:0], div_ge};
    mul_fix      = cond_neg(mul_next, neg_q);
    quo_fix      = XLEN'(cond_neg(DW'(div_quo_next), neg_q));
    rem_fix      = XLEN'(cond_neg(DW'(div_rem_next[XLEN-1:0]), neg_q));
    case (f3_q)
      F3_MUL:                      calc_res = mul_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: calc_res = mul_fix[DW-1:XLEN];
      F3_DIV, F3_DIVU:             calc_res = quo_fix;
      default:                     calc_res = rem_fix;
    endcase
  end

  // Next-state, datapath updates and the combinational stall
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    f3_d     = f3_q;
    result_d = result_q;
    rv_d     = 1'b0;
    stall    = 1'b0;

    case (state_q)
      IDLE: begin
        stall = op_valid & ~flush & ~rst;
        if (op_valid && !flush) begin
          f3_d  = funct3;
          neg_d = (funct3 == F3_REM) ? neg1 : (neg1 ^ neg2);
          cnt_d = '0;
          rem_d = '0;
          if (fast) begin
            result_d = fast_res;
            rv_d     = 1'b1;
            state_d  = DONE;
          end else begin
            acc_d   = funct3[2] ? DW'(abs1) : DW'(abs2);
            opnd_d  = funct3[2] ? abs2 : abs1;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall = ~rst;
          cnt_d = cnt_q + CNT_W'(1);
          if (f3_q[2]) begin
            acc_d = {acc_q[DW-1:XLEN], div_quo_next};
            rem_d = div_rem_next;
          end else begin
            acc_d = mul_next;
          end
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            result_d = calc_res;
            rv_d     = 1'b1;
            cnt_d    = '0;
            state_d  = DONE;
          end
        end
      end

      DONE: begin
        if (flush)     state_d = IDLE;
        else if (hold) rv_d    = 1'b1;
        else           state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      f3_q     <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      f3_q     <= f3_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign result       = result_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed table, corner sequences and random ops vs. an arithmetic model.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  funct3;
  logic [31:0] src1, src2;
  logic        flush, hold;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;

  int n_cmp = 0;
  int n_bad = 0;

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .funct3       (funct3),
    .src1         (src1),
    .src2         (src2),
    .flush        (flush),
    .hold         (hold),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stalls;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference built from the ISA definition using wide integer math
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); return p[31:0]; end
      3'd1: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); return p[63:32]; end
      3'd2: begin p = 64'(longint'($signed(a)) * longint'({32'd0, b})); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Waits (bounded) for result_valid; entered just after a rising edge, returns at the negedge of the valid cycle
  task automatic wait_done(output logic [31:0] res, output int stalls, output bit timeout);
    stalls  = 0;
    timeout = 1'b1;
    res     = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (result_valid) begin
        res     = result;
        timeout = 1'b0;
        if (stall) stalls += 1000;
        break;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
    end
    if (timeout) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no result_valid expected result_valid within 100 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_st);
    logic [31:0] res;
    int          st;
    bit          to;
    op_valid = 1'b1; funct3 = f3; src1 = a; src2 = b;
    wait_done(res, st, to);
    if (!to) begin
      chk({name, "_result"}, res, exp);
      chk({name, "_stalls"}, 32'(st), 32'(exp_st));
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl[14];
  logic [31:0] r, a, b;
  logic [2:0]  f;
  int          st, rv_cnt, st_cnt;
  bit          to;

  initial begin
    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    tbl[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    tbl[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    tbl[8]  = '{3'd5, 32'd10,         32'd0,         32'hFFFF_FFFF, 1};
    tbl[9]  = '{3'd7, 32'd10,         32'd0,         32'd10,        1};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    tbl[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    tbl[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};

    rst = 1'b1; op_valid = 1'b0; funct3 = '0; src1 = '0; src2 = '0; flush = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_rv", 32'(result_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].stalls);

    // Flush in IDLE: the operation must not start
    op_valid = 1'b1; funct3 = 3'd0; src1 = 32'd3; src2 = 32'd4; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    rv_cnt = 0; st_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
      if (stall) st_cnt++;
      @(posedge clk); #1;
    end
    chk("idle_flush_no_rv", 32'(rv_cnt), 32'd0);
    chk("idle_flush_no_stall", 32'(st_cnt), 32'd0);

    // Flush at CALC cycle 10
    op_valid = 1'b1; funct3 = 3'd0; src1 = 32'd1234; src2 = 32'd5678;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("calc_flush_stall", 32'(stall), 32'd0);
    chk("calc_flush_rv", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    rv_cnt = 0; st_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid) rv_cnt++;
      if (stall) st_cnt++;
      @(posedge clk); #1;
    end
    chk("calc_flush_never_rv", 32'(rv_cnt), 32'd0);
    chk("calc_flush_no_stall", 32'(st_cnt), 32'd0);
    run_op("after_flush", 3'd0, 32'd6, 32'd7, 32'd42, 33);

    // Reset at CALC cycle 10
    op_valid = 1'b1; funct3 = 3'd0; src1 = 32'd99; src2 = 32'd77;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("calc_rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 32'(stall), 32'd0);
    chk("post_rst_rv", 32'(result_valid), 32'd0);
    chk("post_rst_result", result, 32'd0);
    @(posedge clk); #1;

    // DIVU completes under hold; a new op_valid must wait until hold drops
    hold = 1'b1;
    op_valid = 1'b1; funct3 = 3'd5; src1 = 32'd100; src2 = 32'd7;
    wait_done(r, st, to);
    if (!to) begin
      chk("hold_first_result", r, 32'd14);
      chk("hold_first_stalls", 32'(st), 32'd33);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        funct3 = 3'd0; src1 = 32'd3; src2 = 32'd5;
        if (k == 2) hold = 1'b0;
        @(negedge clk);
        chk($sformatf("hold_rv_%0d", k), 32'(result_valid), 32'd1);
        chk($sformatf("hold_result_%0d", k), result, 32'd14);
        chk($sformatf("hold_stall_%0d", k), 32'(stall), 32'd0);
      end
      @(posedge clk); #1;
      wait_done(r, st, to);
      if (!to) begin
        chk("after_hold_result", r, 32'd15);
        chk("after_hold_stalls", 32'(st), 32'd33);
      end
      @(posedge clk); #1;
      op_valid = 1'b0;
    end
    hold = 1'b0;

    // Flush while DONE is held
    hold = 1'b1;
    op_valid = 1'b1; funct3 = 3'd7; src1 = 32'd9; src2 = 32'd0;
    wait_done(r, st, to);
    if (!to) chk("done_flush_pre", r, 32'd9);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; hold = 1'b0;
    @(negedge clk);
    chk("done_flush_rv", 32'(result_valid), 32'd0);
    @(posedge clk); #1;

    // Random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d_f%0d_%h_%h", i, f, a, b), f, a, b, ref_model(f, a, b), exp_stalls(f, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
